ahb_sram_slave: RTL and testbench

AHB-Lite responder that terminates one slave port of the generated AHB interconnect. It is the completer side of the bus: it accepts address phases from whichever master the slave-side arbiter has granted, then serves single-word, halfword or byte reads and writes to an internal register-array memory. It has a programmable number of wait states and produces the two-cycle AHB ERROR response for illegal accesses.

---
 rtl/ahb_sram_slave_pkg.sv | 43 ++++
 rtl/ahb_sram_slave_byte_strobe.sv | 22 ++
 rtl/ahb_sram_slave.sv | 143 ++++++++++++++
 tb/tb_ahb_sram_slave.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite types and encodings for the SRAM responder and future
// peripheral slaves.
//   mas_send_type : master -> slave payload (haddr, hwdata, htrans, hburst, hsize, hwrite)
//   slv_send_type : slave -> master payload (hreadyout, hrdata, hresp)
package ahb_sram_slave_pkg;

   localparam int AHB_ADDR_W = 32;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      ERR1,
      ERR2
   } ahb_slv_state_e;

   typedef struct packed {
      logic [AHB_ADDR_W-1:0] haddr;
      logic [31:0]           hwdata;
      logic [1:0]            htrans;
      logic [2:0]            hburst;
      logic [2:0]            hsize;
      logic                  hwrite;
   } mas_send_type;

   typedef struct packed {
      logic        hreadyout;
      logic [31:0] hrdata;
      logic        hresp;
   } slv_send_type;

endpackage

// File: rtl/ahb_sram_slave_byte_strobe.sv
// Little-endian byte-lane enables from transfer size and low address bits.
//   hsize : AHB transfer size (byte/half/word)
//   addr  : haddr[1:0] of the transfer
//   wstrb : one enable per byte lane of the 32-bit data bus
module ahb_byte_strobe
   import ahb_sram_slave_pkg::*;
(
   input  logic [2:0] hsize,
   input  logic [1:0] addr,
   output logic [3:0] wstrb
);

   always_comb begin
      wstrb = 4'b1111;
      case (hsize)
         HSIZE_BYTE: wstrb = 4'b0001 << addr;
         HSIZE_HALF: wstrb = addr[1] ? 4'b1100 : 4'b0011;
         default:    wstrb = 4'b1111;
      endcase
   end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a register-array memory with programmable
// wait states and a two-cycle ERROR response for illegal accesses.
//   hclk, hreset_n : bus clock, async active-low reset
//   hsel, hready   : slave select and bus-level ready (gates address phase)
//   slave_in       : master payload
//   slave_out      : hreadyout / hrdata / hresp
//
// state | meaning
// IDLE  | ready; completes a pending legal data phase when pend_q is set
// WAIT  | inserting wait states, down-counter cnt_q running
// ERR1  | first ERROR cycle (hreadyout=0)
// ERR2  | second ERROR cycle (hreadyout=1), may accept next address phase
module ahb_sram_slave
   import ahb_sram_slave_pkg::*;
#(
   parameter int MEM_DEPTH   = 1024,
   parameter int WAIT_STATES = 0,
   parameter int ADDR_W      = 32
) (
   input  logic         hclk,
   input  logic         hreset_n,
   input  logic         hsel,
   input  logic         hready,
   input  mas_send_type slave_in,
   output slv_send_type slave_out
);

   localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
   localparam logic [3:0] WS = 4'(WAIT_STATES);

   ahb_slv_state_e   state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic [IDX_W+1:0] addr_q, addr_d;
   logic [2:0]       size_q, size_d;
   logic             write_q, write_d;
   logic             hreadyout_q, hreadyout_d;
   logic             hresp_q, hresp_d;

   logic [31:0]       mem_q [MEM_DEPTH];
   logic [ADDR_W-1:0] haddr;
   logic              accept, illegal, done, wr_en, rd_en;
   logic [3:0]        wstrb;
   logic              unused_bits;

   assign haddr       = slave_in.haddr[ADDR_W-1:0];
   assign unused_bits = ^slave_in.hburst;

   always_comb begin
      accept  = hsel && hready &&
                (slave_in.htrans == HTRANS_NONSEQ || slave_in.htrans == HTRANS_SEQ);
      illegal = (slave_in.hsize > HSIZE_WORD) ||
                (slave_in.hsize == HSIZE_HALF && haddr[0]) ||
                (slave_in.hsize == HSIZE_WORD && haddr[1:0] != 2'b00) ||
                ((haddr >> 2) >= ADDR_W'(MEM_DEPTH));
      done    = (state_q == IDLE) && pend_q;
      wr_en   = done && write_q;
      rd_en   = done && !write_q;

      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      addr_d  = addr_q;
      size_d  = size_q;
      write_d = write_q;

      case (state_q)
         IDLE, ERR2: begin
            state_d = IDLE;
            pend_d  = 1'b0;
            if (accept) begin
               addr_d  = haddr[IDX_W+1:0];
               size_d  = slave_in.hsize;
               write_d = slave_in.hwrite;
               if (illegal) begin
                  state_d = ERR1;
               end else begin
                  pend_d = 1'b1;
                  if (WS != 4'd0) begin
                     state_d = WAIT;
                     cnt_d   = WS;
                  end
               end
            end
         end
         WAIT: begin
            cnt_d = cnt_q - 4'd1;
            // terminal count: the following cycle is the completing data phase
            if (cnt_q == 4'd1) state_d = IDLE;
         end
         ERR1:    state_d = ERR2;
         default: state_d = IDLE;
      endcase

      hreadyout_d = !(state_d == WAIT || state_d == ERR1);
      hresp_d     = (state_d == ERR1 || state_d == ERR2) ? HRESP_ERROR : HRESP_OKAY;
   end

   always_ff @(posedge hclk or negedge hreset_n) begin
      if (!hreset_n) begin
         state_q     <= IDLE;
         cnt_q       <= 4'd0;
         pend_q      <= 1'b0;
         addr_q      <= '0;
         size_q      <= HSIZE_BYTE;
         write_q     <= 1'b0;
         hreadyout_q <= 1'b1;
         hresp_q     <= HRESP_OKAY;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         pend_q      <= pend_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         write_q     <= write_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
      end
   end

   ahb_byte_strobe u_strobe (
      .hsize (size_q),
      .addr  (addr_q[1:0]),
      .wstrb (wstrb)
   );

   // memory is deliberately not reset; pend_q is, so a write caught by reset is dropped
   always_ff @(posedge hclk) begin
      if (wr_en) begin
         for (int b = 0; b < 4; b++) begin
            if (wstrb[b]) mem_q[addr_q[IDX_W+1:2]][8*b +: 8] <= slave_in.hwdata[8*b +: 8];
         end
      end
   end

   // read data is the whole word, only in the completing cycle
   always_comb begin
      slave_out.hreadyout = hreadyout_q;
      slave_out.hresp     = hresp_q;
      slave_out.hrdata    = rd_en ? mem_q[addr_q[IDX_W+1:2]] : 32'd0;
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
module tb_ahb_sram_slave;
   import ahb_sram_slave_pkg::*;

   logic         hclk = 1'b0;
   logic         hreset_n = 1'b0;
   logic         hsel0 = 1'b0, hsel2 = 1'b0, hsel3 = 1'b0;
   logic         hready;
   mas_send_type m;
   slv_send_type o0, o2, o3, cur;
   int           act = 0;
   int           vectors = 0;
   int           errors = 0;

   always #5 hclk = ~hclk;

   always_comb begin
      case (act)
         2:       cur = o2;
         3:       cur = o3;
         default: cur = o0;
      endcase
   end
   assign hready = cur.hreadyout;

   ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(0), .ADDR_W(32)) u_dut0 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel0), .hready(hready),
      .slave_in(m), .slave_out(o0));
   ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(2), .ADDR_W(32)) u_dut2 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel2), .hready(hready),
      .slave_in(m), .slave_out(o2));
   ahb_sram_slave #(.MEM_DEPTH(1024), .WAIT_STATES(3), .ADDR_W(32)) u_dut3 (
      .hclk(hclk), .hreset_n(hreset_n), .hsel(hsel3), .hready(hready),
      .slave_in(m), .slave_out(o3));

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic drive(input logic s, input logic [1:0] tr, input logic [31:0] a,
                        input logic [2:0] sz, input logic w);
      hsel0    = s && (act == 0);
      hsel2    = s && (act == 2);
      hsel3    = s && (act == 3);
      m.htrans = tr;
      m.haddr  = a;
      m.hsize  = sz;
      m.hwrite = w;
      m.hburst = 3'b000;
   endtask

   task automatic idle();
      drive(1'b0, HTRANS_IDLE, 32'h0, HSIZE_WORD, 1'b0);
   endtask

   task automatic run_until_ready(output int n);
      n = 0;
      while (cur.hreadyout !== 1'b1 && n < 32) begin
         tick();
         n++;
      end
   endtask

   task automatic test_reset();
      m = '0;
      hreset_n = 1'b0;
      #12;
      vectors++; if (o0.hreadyout !== 1'b1) begin errors++; $display("FAIL rst_ready got %0b exp 1", o0.hreadyout); end
      vectors++; if (o0.hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp got %0b exp 0", o0.hresp); end
      vectors++; if (o3.hrdata !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", o3.hrdata); end
      @(negedge hclk);
      hreset_n = 1'b1;
      tick();
   endtask

   task automatic test_zero_wait();
      act = 0;
      drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1);
      tick();
      m.hwdata = 32'hDEADBEEF;
      drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0);
      vectors++; if (cur.hreadyout !== 1'b1) begin errors++; $display("FAIL zw_wr_ready got %0b exp 1", cur.hreadyout); end
      vectors++; if (cur.hrdata !== 32'h0) begin errors++; $display("FAIL zw_wr_rdata got %h exp 0", cur.hrdata); end
      tick();
      idle();
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hresp !== 1'b0) begin errors++; $display("FAIL zw_rd_resp got %0b/%0b exp 1/0", cur.hreadyout, cur.hresp); end
      vectors++; if (cur.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL zw_rd_data got %h exp deadbeef", cur.hrdata); end
      tick();
      vectors++; if (cur.hrdata !== 32'h0) begin errors++; $display("FAIL zw_rd_hold0 got %h exp 0", cur.hrdata); end
   endtask

   task automatic test_wait_states();
      int n;
      act = 2;
      drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b1);
      tick();
      m.hwdata = 32'hDEADBEEF;
      idle();
      run_until_ready(n);
      vectors++; if (n !== 2) begin errors++; $display("FAIL ws_wr_waits got %0d exp 2", n); end
      tick();
      drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0);
      tick();
      idle();
      m.hwdata = 32'h0;
      vectors++; if (cur.hreadyout !== 1'b0 || cur.hrdata !== 32'h0) begin errors++; $display("FAIL ws_c1 got %0b/%h exp 0/0", cur.hreadyout, cur.hrdata); end
      tick();
      vectors++; if (cur.hreadyout !== 1'b0 || cur.hrdata !== 32'h0) begin errors++; $display("FAIL ws_c2 got %0b/%h exp 0/0", cur.hreadyout, cur.hrdata); end
      tick();
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL ws_c3 got %0b/%h exp 1/deadbeef", cur.hreadyout, cur.hrdata); end
      tick();
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hrdata !== 32'h0) begin errors++; $display("FAIL ws_c4 got %0b/%h exp 1/0", cur.hreadyout, cur.hrdata); end
   endtask

   task automatic test_byte_lanes();
      act = 0;
      drive(1'b1, HTRANS_NONSEQ, 32'h11, HSIZE_BYTE, 1'b1);
      tick();
      m.hwdata = 32'h0000AA00;
      drive(1'b1, HTRANS_NONSEQ, 32'h12, HSIZE_HALF, 1'b1);
      vectors++; if (cur.hreadyout !== 1'b1) begin errors++; $display("FAIL bl_byte_ready got %0b exp 1", cur.hreadyout); end
      tick();
      m.hwdata = 32'h55660000;
      drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0);
      tick();
      idle();
      m.hwdata = 32'h0;
      vectors++; if (cur.hrdata !== 32'h5566AAEF) begin errors++; $display("FAIL bl_read got %h exp 5566aaef", cur.hrdata); end
      tick();
   endtask

   task automatic test_error();
      act = 0;
      drive(1'b1, HTRANS_NONSEQ, 32'h13, HSIZE_HALF, 1'b1);
      tick();
      m.hwdata = 32'hFFFFFFFF;
      idle();
      vectors++; if (cur.hreadyout !== 1'b0 || cur.hresp !== 1'b1) begin errors++; $display("FAIL err_mis_c1 got %0b/%0b exp 0/1", cur.hreadyout, cur.hresp); end
      tick();
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hresp !== 1'b1) begin errors++; $display("FAIL err_mis_c2 got %0b/%0b exp 1/1", cur.hreadyout, cur.hresp); end
      drive(1'b1, HTRANS_NONSEQ, 32'h1000, HSIZE_WORD, 1'b1);
      tick();
      idle();
      vectors++; if (cur.hreadyout !== 1'b0 || cur.hresp !== 1'b1) begin errors++; $display("FAIL err_range_c1 got %0b/%0b exp 0/1", cur.hreadyout, cur.hresp); end
      tick();
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hresp !== 1'b1) begin errors++; $display("FAIL err_range_c2 got %0b/%0b exp 1/1", cur.hreadyout, cur.hresp); end
      drive(1'b1, HTRANS_NONSEQ, 32'h10, 3'd3, 1'b0);
      tick();
      idle();
      vectors++; if (cur.hreadyout !== 1'b0 || cur.hresp !== 1'b1 || cur.hrdata !== 32'h0) begin errors++; $display("FAIL err_size_c1 got %0b/%0b/%h exp 0/1/0", cur.hreadyout, cur.hresp, cur.hrdata); end
      tick();
      drive(1'b1, HTRANS_NONSEQ, 32'h10, HSIZE_WORD, 1'b0);
      tick();
      idle();
      m.hwdata = 32'h0;
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hresp !== 1'b0) begin errors++; $display("FAIL err_after_resp got %0b/%0b exp 1/0", cur.hreadyout, cur.hresp); end
      vectors++; if (cur.hrdata !== 32'h5566AAEF) begin errors++; $display("FAIL err_after_data got %h exp 5566aaef", cur.hrdata); end
      tick();
   endtask

   task automatic test_back_to_back();
      act = 0;
      drive(1'b1, HTRANS_NONSEQ, 32'h20, HSIZE_WORD, 1'b1);
      tick();
      m.hwdata = 32'h12345678;
      drive(1'b1, HTRANS_SEQ, 32'h20, HSIZE_WORD, 1'b0);
      vectors++; if (cur.hreadyout !== 1'b1) begin errors++; $display("FAIL b2b_wr_ready got %0b exp 1", cur.hreadyout); end
      tick();
      idle();
      m.hwdata = 32'h0;
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hrdata !== 32'h12345678) begin errors++; $display("FAIL b2b_read got %0b/%h exp 1/12345678", cur.hreadyout, cur.hrdata); end
      tick();
   endtask

   task automatic test_reset_in_wait();
      int n;
      act = 3;
      drive(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b1);
      tick();
      m.hwdata = 32'hCAFEF00D;
      idle();
      run_until_ready(n);
      vectors++; if (n !== 3) begin errors++; $display("FAIL rw_setup_waits got %0d exp 3", n); end
      tick();
      drive(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b1);
      tick();
      m.hwdata = 32'h0BADBEEF;
      idle();
      vectors++; if (cur.hreadyout !== 1'b0) begin errors++; $display("FAIL rw_in_wait got %0b exp 0", cur.hreadyout); end
      tick();
      hreset_n = 1'b0;
      #1;
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hresp !== 1'b0) begin errors++; $display("FAIL rw_async got %0b/%0b exp 1/0", cur.hreadyout, cur.hresp); end
      tick();
      hreset_n = 1'b1;
      tick();
      drive(1'b1, HTRANS_NONSEQ, 32'h30, HSIZE_WORD, 1'b0);
      tick();
      idle();
      m.hwdata = 32'h0;
      run_until_ready(n);
      vectors++; if (n !== 3 || cur.hrdata !== 32'hCAFEF00D) begin errors++; $display("FAIL rw_readback got %0d/%h exp 3/cafef00d", n, cur.hrdata); end
      tick();
      drive(1'b1, HTRANS_IDLE, 32'h30, HSIZE_WORD, 1'b0);
      tick();
      idle();
      vectors++; if (cur.hreadyout !== 1'b1 || cur.hresp !== 1'b0 || cur.hrdata !== 32'h0) begin errors++; $display("FAIL rw_idle_okay got %0b/%0b/%h exp 1/0/0", cur.hreadyout, cur.hresp, cur.hrdata); end
      tick();
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_byte_lanes();
      test_error();
      test_back_to_back();
      test_reset_in_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp finish");
      $fatal(1, "watchdog");
   end

endmodule
